// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment scan display.
//   SEG_OFF   : active-high segment pattern with every segment off
//   SEG_TABLE : active-high {g,f,e,d,c,b,a} pattern for each hex value 0-F,
//               indexed directly by the digit value
package sevenseg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Entry 15 is written first so that SEG_TABLE[v] yields the pattern for v.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
    7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
  };

  // Table lookup kept as a function so callers never index the constant directly.
  function automatic logic [6:0] seg_lookup(input logic [3:0] value);
    return SEG_TABLE[value];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-to-seven-segment decoder, active-high output.
//   digit_i : 4-bit value 0-F
//   seg_o   : {g,f,e,d,c,b,a}, 1 = segment lit
module seg7_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  // Pure table lookup; output polarity is applied by the caller.
  always_comb begin
    seg_o = seg_lookup(digit_i);
  end

endmodule

// File: rtl/sevenseg_scan.sv
// Four-digit multiplexed seven-segment driver for a common-anode display.
// Inputs are captured once per frame so a digit never changes mid-scan, and
// every digit slot opens with an all-off blanking interval against ghosting.
//   clk, rst_n          : clock, asynchronous active-low reset
//   digit1..digit4      : hex digit values, digit1 leftmost
//   dp                  : decimal-point enables, dp[3]=digit1 .. dp[0]=digit4
//   an                  : anode drive, an[3]=digit1 .. an[0]=digit4
//   seg, seg_dp         : segments {g,f,e,d,c,b,a} and decimal point
//   frame_tick          : one-cycle pulse after the last slot of each frame
// All outputs are registered and therefore reflect the scan position one clock late.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int BLANK_CYCLES = 500,
  parameter int LZB          = 1,
  parameter int AN_ACT_LOW   = 1,
  parameter int SEG_ACT_LOW  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic [3:0] digit4,
  input  logic [3:0] dp,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       seg_dp,
  output logic       frame_tick
);

  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  // Idle (inactive) levels of the physical outputs for the chosen polarity.
  localparam logic [3:0] AN_IDLE  = (AN_ACT_LOW  != 0) ? 4'hF  : 4'h0;
  localparam logic [6:0] SEG_IDLE = (SEG_ACT_LOW != 0) ? ~SEG_OFF : SEG_OFF;
  localparam logic       DP_IDLE  = (SEG_ACT_LOW != 0) ? 1'b1  : 1'b0;

  generate
    if (DIV < BLANK_CYCLES + 1) begin : g_bad_cfg
      $error("sevenseg_scan: slot length DIV must be at least BLANK_CYCLES+1");
    end
  endgenerate

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       slot_q, slot_d;
  logic [15:0]      snap_dig_q;       // {digit1, digit2, digit3, digit4}
  logic [3:0]       snap_dp_q;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             seg_dp_q, seg_dp_d;
  logic             frame_tick_q;

  logic             cnt_end_s;
  logic             frame_end_s;
  logic [3:0]       cur_digit_s;
  logic             cur_dp_s;
  logic             dark_s;
  logic [3:0]       an_act_s;
  logic [6:0]       dec_s;
  logic [6:0]       seg_act_s;
  logic             dp_act_s;

  seg7_decode u_decode (
    .digit_i (cur_digit_s),
    .seg_o   (dec_s)
  );

  // Next scan position, slot-muxed snapshot digit and next output values.
  always_comb begin
    cnt_end_s   = (cnt_q == CNT_LAST);
    frame_end_s = cnt_end_s && (slot_q == 2'd3);

    if (cnt_end_s) begin
      cnt_d  = {CNT_W{1'b0}};
      slot_d = slot_q + 2'd1;
    end else begin
      cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      slot_d = slot_q;
    end

    // Slot k shows digit(k+1), which sits at anode/dp bit 3-k.
    case (slot_q)
      2'd0:    begin cur_digit_s = snap_dig_q[15:12]; cur_dp_s = snap_dp_q[3]; end
      2'd1:    begin cur_digit_s = snap_dig_q[11:8];  cur_dp_s = snap_dp_q[2]; end
      2'd2:    begin cur_digit_s = snap_dig_q[7:4];   cur_dp_s = snap_dp_q[1]; end
      2'd3:    begin cur_digit_s = snap_dig_q[3:0];   cur_dp_s = snap_dp_q[0]; end
      default: begin cur_digit_s = 4'h0;              cur_dp_s = 1'b0;         end
    endcase

    // Segments go dark in the blanking window and for a suppressed leading zero;
    // the anode is still driven in the latter case.
    if (cnt_q < CNT_BLANK) begin
      an_act_s = 4'b0000;
      dark_s   = 1'b1;
    end else begin
      an_act_s = 4'b1000 >> slot_q;
      dark_s   = (LZB != 0) && (slot_q == 2'd0) && (cur_digit_s == 4'h0);
    end

    if (dark_s) begin
      seg_act_s = SEG_OFF;
      dp_act_s  = 1'b0;
    end else begin
      seg_act_s = dec_s;
      dp_act_s  = cur_dp_s;
    end

    an_d     = (AN_ACT_LOW  != 0) ? ~an_act_s  : an_act_s;
    seg_d    = (SEG_ACT_LOW != 0) ? ~seg_act_s : seg_act_s;
    seg_dp_d = (SEG_ACT_LOW != 0) ? ~dp_act_s  : dp_act_s;
  end

  // Prescaler, slot counter, per-frame snapshot and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= {CNT_W{1'b0}};
      slot_q       <= 2'd0;
      snap_dig_q   <= 16'h0000;
      snap_dp_q    <= 4'h0;
      an_q         <= AN_IDLE;
      seg_q        <= SEG_IDLE;
      seg_dp_q     <= DP_IDLE;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      slot_q       <= slot_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      seg_dp_q     <= seg_dp_d;
      frame_tick_q <= frame_end_s;
      if (frame_end_s) begin
        snap_dig_q <= {digit1, digit2, digit3, digit4};
        snap_dp_q  <= dp;
      end else begin
        snap_dig_q <= snap_dig_q;
        snap_dp_q  <= snap_dp_q;
      end
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign seg_dp     = seg_dp_q;
  assign frame_tick = frame_tick_q;

endmodule
